// File: rtl/arb_mux_n_1_if.sv
`default_nettype none
// ============================================================================
//  Module   : arb_mux_n_1_if
//  Purpose  : Bundle of the N producer channels, the single consumer channel
//             and the steering controls of the arb_mux_n_1 selector.
//  Ports    : mode, sel                     - steering (fixed / round-robin)
//             in_data, in_valid, in_ready   - N packed producer channels
//             out_data, out_valid, out_ready, out_sel - consumer channel
//  Modports : master - producers/consumer side (drives requests, out_ready)
//             slave  - the selector itself
//  Revision : 1.0 - initial release
// ============================================================================
interface arb_mux_n_1_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_sel;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/arb_mux_n_1.sv
`default_nettype none
// ============================================================================
//  Module   : arb_mux_n_1
//  Purpose  : N-input, WIDTH-bit selector with a registered output stage and
//             valid/ready handshakes.  mode=1 steers channel sel to the
//             output; mode=0 arbitrates round-robin among valid channels.
//             One cycle latency, one transfer per cycle sustained.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - arb_mux_n_1_if.slave (mode, sel, in_data, in_valid,
//                     in_ready, out_data, out_valid, out_ready, out_sel)
//  Revision : 1.0 - initial release
// ============================================================================
module arb_mux_n_1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  arb_mux_n_1_if.slave bus
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load;
  logic             w_fix_hit;
  logic [SEL_W-1:0] w_fix_idx;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_cand_hit;
  logic [SEL_W-1:0] w_cand_idx;
  logic             w_grant;
  logic [N-1:0]     w_in_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_rr_next;

  // The output register may take a new word when empty or being drained.
  assign w_load = !r_out_valid || bus.out_ready;

  // Fixed select: sel values with no matching channel (>= N) never hit.
  always_comb begin
    w_fix_hit = 1'b0;
    w_fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        w_fix_hit = bus.in_valid[i];
        w_fix_idx = SEL_W'(i);
      end
    end
  end

  // Round-robin: scan from r_rr_ptr upward with wrap, first valid wins.
  always_comb begin
    int idx;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!w_rr_hit && bus.in_valid[idx]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SEL_W'(idx);
      end
    end
  end

  assign w_cand_hit = bus.mode ? w_fix_hit : w_rr_hit;
  assign w_cand_idx = bus.mode ? w_fix_idx : w_rr_idx;

  // Gating with rst_n keeps every in_ready low while reset is asserted.
  assign w_grant = rst_n && w_load && w_cand_hit;

  // One-hot ready and the data mux share the same decoded index.
  always_comb begin
    w_in_ready = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand_idx == SEL_W'(i)) begin
        w_in_ready[i] = w_grant;
        w_sel_data    = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_rr_next = (w_cand_idx == SEL_W'(N - 1)) ? '0 : w_cand_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant) begin
      r_out_data  <= w_sel_data;
      r_out_valid <= 1'b1;
      r_out_sel   <= w_cand_idx;
      // Only round-robin transfers advance the fairness pointer.
      if (!bus.mode) begin
        r_rr_ptr <= w_rr_next;
      end
    end else if (bus.out_ready) begin
      // Drain: data and index stay as last loaded.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: doc/arb_mux_n_1.md
Name: arb_mux_n_1

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready handshake on every channel.
- Two modes:
  - Fixed-select mode: steered by sel, the plain 2:1 mux behaviour generalised to N inputs.
  - Round-robin mode: fair arbitration among all valid requesters.
- Sits between multiple producers (e.g. writeback sources, memory request ports) and one consumer; gives one-cycle latency and full throughput.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N), width of sel and out_sel; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = round-robin arbitration, 1 = fixed select by sel.
- sel  input  SEL_W  channel index used when mode=1; values >= N select no channel.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready=0 while rst_n=0.
- Load enable: load = !out_valid || out_ready. The output register accepts a new word only when load=1, so back-to-back transfers run at one per cycle when out_ready is held high.
- Grant, mode=1:
  - Candidate is channel sel only.
  - grant[sel] = load && in_valid[sel]; all other grants are 0.
  - sel >= N means no grant.
- Grant, mode=0:
  - Scan channels starting at rr_ptr, ascending with wrap-around (rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1).
  - The first channel with in_valid=1 is granted if load=1.
- in_ready = grant, combinational from in_valid, mode, sel, rr_ptr, out_valid and out_ready.
  - in_ready[i] never depends on in_data.
  - At most one bit is set.
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. Next cycle out_data = channel i data, out_sel = i, out_valid = 1. Latency is exactly 1 cycle.
- Output hold: if out_valid=1 && out_ready=0, then out_data, out_sel and out_valid hold unchanged and all in_ready are 0.
- Drain: if out_ready=1 and no grant occurs, out_valid goes to 0 next cycle; out_data and out_sel keep their last values.
- rr_ptr:
  - Updates only on a transfer while mode=0: rr_ptr = (granted index + 1), wrapping N-1 -> 0.
  - Unchanged in mode=1 and on idle cycles.
- Mode/sel changes: take effect combinationally for the next grant decision. A word already in the output register is unaffected.
- Fairness: in mode=0, with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.
- Producer rule (checked by assertion in the bench, not enforced): a producer holds in_valid and in_data stable until its handshake completes.
- Mid-operation reset: an asynchronous drop of rst_n discards any held word (out_valid=0 immediately) and returns rr_ptr to 0.

Test Plan:
- Reset, mode=1, sel=2, in_valid=4'b0100, ch2 data=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEAD_BEEF, out_sel=2, out_valid=1.
- mode=1, sel=3, in_valid=4'b0111 -> in_ready=4'b0000 and out_valid falls to 0; then sel=5 with N=6 and only channel 5 valid -> out_sel=5.
- mode=0, all four channels valid, data = index+1, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 1,2,3,4,1,2,3,4; in_ready one-hot every cycle.
- mode=0, out_valid=1 holding 32'h0000_0011, out_ready=0 for 3 cycles -> out_data stays 32'h0000_0011, in_ready=0, rr_ptr unchanged; out_ready=1 -> next word loads the following cycle with no bubble.
- mode=0, rr_ptr=3, only ch1 valid -> ch1 granted (wrap-around search), rr_ptr becomes 2.
- Transfer in flight, rst_n pulsed low mid-cycle -> out_valid=0, out_data=0 and out_sel=0 immediately; after release, the first round-robin grant starts from ch0.
